rom_fetch_unit: RTL

ROM_FETCH_UNIT -- requirements
Module: rom_fetch_unit

---
 rtl/rom_fetch_unit_if.sv | 25 ++
 rtl/rom_fetch_unit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/rom_fetch_unit_if.sv
// rom_fetch_unit_if: ROM request/response and instruction-delivery signals of the fetch unit.
// master = fetch unit side, slave = ROM / consumer / redirect source side.
interface rom_fetch_unit_if;
  logic [31:0] address;
  logic        mem_read;
  logic [1:0]  size;
  logic [63:0] data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        fault;

  modport master (
    output address, mem_read, size, instr, instr_pc, instr_valid, fault,
    input  data, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  address, mem_read, size, instr, instr_pc, instr_valid, fault,
    output data, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/rom_fetch_unit.sv
// rom_fetch_unit: sequential ROM fetcher with a DEPTH-entry instruction buffer and redirect.
// Optional: define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects into a HALT state.
module rom_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input logic             clock,
  input logic             reset,
  rom_fetch_unit_if.master bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [31:0]   pc_r, address_r, pend_pc_r, instr_r, instr_pc_r;
  logic          mem_read_r, pending_r, instr_valid_r, fault_r;
  logic [0:0]    state_r;
  logic [PW-1:0] head_r, tail_r;
  logic [CW-1:0] count_r;
  logic [31:0]   buf_instr_r [DEPTH];
  logic [31:0]   buf_pc_r    [DEPTH];

  logic          pop_s, cap_s, issue_s, misalign_s;
  logic [SW-1:0] occupancy_s;
  logic [CW-1:0] count_n_s;
  logic [PW-1:0] head_n_s;
  logic [31:0]   target_s, instr_n_s, instr_pc_n_s;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign_s = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
  assign target_s   = bus.redirect_pc;
`else
  assign misalign_s = 1'b0;
  assign target_s   = {bus.redirect_pc[31:2], 2'b00};
`endif

  assign bus.address     = address_r;
  assign bus.mem_read    = mem_read_r;
  assign bus.size        = 2'b10;
  assign bus.instr       = instr_r;
  assign bus.instr_pc    = instr_pc_r;
  assign bus.instr_valid = instr_valid_r;
  assign bus.fault       = fault_r;

  // Next buffer occupancy, issue decision and the value the head outputs will take.
  always_comb begin
    pop_s        = (count_r != CW'(0)) && bus.instr_ready;
    cap_s        = pending_r && !bus.redirect;
    count_n_s    = count_r + CW'(cap_s) - CW'(pop_s);
    head_n_s     = head_r + PW'(pop_s);
    // Entries held plus responses still owed once this edge settles; the new request needs a slot too.
    occupancy_s  = SW'(count_r) + SW'(pending_r) + SW'(mem_read_r) - SW'(pop_s);
    issue_s      = (state_r == ST_RUN) && !bus.redirect && (occupancy_s < SW'(DEPTH));
    instr_n_s    = 32'h0000_0000;
    instr_pc_n_s = 32'h0000_0000;
    if (count_n_s == CW'(0)) begin
      instr_n_s    = 32'h0000_0000;
      instr_pc_n_s = 32'h0000_0000;
    end else if (cap_s && (tail_r == head_n_s)) begin
      instr_n_s    = bus.data[31:0];
      instr_pc_n_s = pend_pc_r;
    end else begin
      instr_n_s    = buf_instr_r[head_n_s];
      instr_pc_n_s = buf_pc_r[head_n_s];
    end
  end

  // Fetch control, buffer pointers and registered head outputs; redirect overrides pop and capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_r          <= RESET_PC;
      address_r     <= RESET_PC;
      pend_pc_r     <= 32'h0000_0000;
      mem_read_r    <= 1'b0;
      pending_r     <= 1'b0;
      instr_valid_r <= 1'b0;
      instr_r       <= 32'h0000_0000;
      instr_pc_r    <= 32'h0000_0000;
      fault_r       <= 1'b0;
      state_r       <= ST_RUN;
      head_r        <= PW'(0);
      tail_r        <= PW'(0);
      count_r       <= CW'(0);
    end else if (bus.redirect) begin
      mem_read_r    <= 1'b0;
      pending_r     <= 1'b0;
      instr_valid_r <= 1'b0;
      instr_r       <= 32'h0000_0000;
      instr_pc_r    <= 32'h0000_0000;
      head_r        <= PW'(0);
      tail_r        <= PW'(0);
      count_r       <= CW'(0);
      if (misalign_s) begin
        state_r <= ST_HALT;
        fault_r <= 1'b1;
      end else begin
        state_r <= ST_RUN;
        fault_r <= 1'b0;
        pc_r    <= target_s;
      end
    end else begin
      pending_r     <= mem_read_r;
      pend_pc_r     <= address_r;
      mem_read_r    <= issue_s;
      if (issue_s) begin
        address_r <= pc_r;
        pc_r      <= pc_r + 32'd4;
      end else begin
        address_r <= address_r;
      end
      if (cap_s) begin
        tail_r <= tail_r + PW'(1);
      end else begin
        tail_r <= tail_r;
      end
      head_r        <= head_n_s;
      count_r       <= count_n_s;
      instr_valid_r <= (count_n_s != CW'(0));
      instr_r       <= instr_n_s;
      instr_pc_r    <= instr_pc_n_s;
    end
  end

  // Buffer storage; contents are only observed through count, so no reset is needed.
  always_ff @(posedge clock) begin
    if (cap_s) begin
      buf_instr_r[tail_r] <= bus.data[31:0];
      buf_pc_r[tail_r]    <= pend_pc_r;
    end
  end
endmodule
